// File: rtl/pcnn_iter_scheduler.sv
// pcnn_iter_scheduler
//   Runs the PCNN engine controller over a frame of several iterations. Each
//   iteration soft-resets the engine, pulses its go, and waits for its done
//   pulse under a watchdog. The pulse-feedback ping-pong bank is flipped
//   after every completed iteration.
//
// Ports
//   clk        in   rising-edge system clock
//   rst        in   asynchronous active-high reset
//   start      in   frame request, only looked at while idle
//   iters      in   iterations per frame, latched on an accepted start (0 => 1)
//   abort      in   cancel the current frame
//   eng_done   in   done pulse from the engine controller
//   eng_go     out  go pulse to the engine
//   eng_rst    out  soft reset to the engine
//   bank_sel   out  ping-pong select for the pulse-feedback buffers
//   iter_cnt   out  completed iterations in the current frame
//   busy       out  high whenever not idle
//   frame_done out  one-cycle pulse when a frame finishes normally
//   timeout    out  sticky watchdog error, cleared by the next accepted start
module pcnn_iter_scheduler #(
  parameter int ITER_W  = 6,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ITER_W-1:0] iters,
  input  logic              abort,
  input  logic              eng_done,
  output logic              eng_go,
  output logic              eng_rst,
  output logic              bank_sel,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERST, S_GO, S_WAIT, S_NEXT, S_FIN, S_ERR, S_ABRT
  } state_t;

  // Last watchdog value before expiry: WAIT lasts exactly TIMEOUT cycles.
  localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [ITER_W-1:0]   iters_lat_reg, iters_lat_next;
  logic [ITER_W-1:0]   iter_cnt_reg, iter_cnt_next;
  logic                bank_sel_reg, bank_sel_next;
  logic                timeout_reg, timeout_next;
  logic [TO_W-1:0]     wdog_reg, wdog_next;
  logic [ITER_W-1:0]   iter_inc;

  assign iter_inc = iter_cnt_reg + ITER_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      iters_lat_reg <= '0;
      iter_cnt_reg  <= '0;
      bank_sel_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      wdog_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      iters_lat_reg <= iters_lat_next;
      iter_cnt_reg  <= iter_cnt_next;
      bank_sel_reg  <= bank_sel_next;
      timeout_reg   <= timeout_next;
      wdog_reg      <= wdog_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    iters_lat_next = iters_lat_reg;
    iter_cnt_next  = iter_cnt_reg;
    bank_sel_next  = bank_sel_reg;
    timeout_next   = timeout_reg;
    wdog_next      = wdog_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next     = S_ERST;
          iters_lat_next = (iters == '0) ? ITER_W'(1) : iters;
          iter_cnt_next  = '0;
          bank_sel_next  = 1'b0;
          timeout_next   = 1'b0;
        end
      end
      S_ERST: state_next = S_GO;
      S_GO: begin
        state_next = S_WAIT;
        wdog_next  = '0;
      end
      S_WAIT: begin
        wdog_next = wdog_reg + TO_W'(1);
        // A done arriving in the expiry cycle still counts as success.
        if (eng_done) begin
          state_next = S_NEXT;
        end else if (wdog_reg == WDOG_LAST) begin
          state_next   = S_ERR;
          timeout_next = 1'b1;
        end
      end
      S_NEXT: begin
        iter_cnt_next = iter_inc;
        bank_sel_next = ~bank_sel_reg;
        state_next    = (iter_inc == iters_lat_reg) ? S_FIN : S_ERST;
      end
      S_FIN:  state_next = S_IDLE;
      S_ERR:  state_next = S_IDLE;
      S_ABRT: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Abort wins over everything; the cancelled step leaves count, bank and
    // error flag untouched.
    if (abort && state_reg != S_IDLE && state_reg != S_ABRT) begin
      state_next    = S_ABRT;
      iter_cnt_next = iter_cnt_reg;
      bank_sel_next = bank_sel_reg;
      timeout_next  = timeout_reg;
    end
  end

  assign eng_rst    = (state_reg == S_ERST) || (state_reg == S_ERR) ||
                      (state_reg == S_ABRT);
  assign eng_go     = (state_reg == S_GO);
  assign frame_done = (state_reg == S_FIN);
  assign busy       = (state_reg != S_IDLE);
  assign bank_sel   = bank_sel_reg;
  assign iter_cnt   = iter_cnt_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_pcnn_iter_scheduler.sv
// Testbench for pcnn_iter_scheduler. Stimulus pushes the expected engine
// control events (eng_rst / eng_go / frame_done cycles) into a queue; a
// monitor pops and compares one entry each time the DUT shows such an event.
module tb_pcnn_iter_scheduler;

  localparam int ITER_W = 6;
  localparam int TO_W   = 16;
  localparam int TMO    = 20;

  localparam int K_RST  = 0;
  localparam int K_GO   = 1;
  localparam int K_DONE = 2;

  logic              clk, rst, start, abort, eng_done;
  logic [ITER_W-1:0] iters;
  logic              eng_go, eng_rst, bank_sel, busy, frame_done, timeout;
  logic [ITER_W-1:0] iter_cnt;

  pcnn_iter_scheduler #(.ITER_W(ITER_W), .TO_W(TO_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .iters(iters), .abort(abort),
    .eng_done(eng_done), .eng_go(eng_go), .eng_rst(eng_rst),
    .bank_sel(bank_sel), .iter_cnt(iter_cnt), .busy(busy),
    .frame_done(frame_done), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int ic;
    int bs;
    int to;
    int gap;   // cycles since previous event, -1 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  int  last_cyc = 0;
  int  n_ev   = 0;
  ev_t e;
  int  k;

  function automatic void push(input int kind, input int ic, input int bs,
                               input int to, input int gap);
    ev_t x;
    x.kind = kind; x.ic = ic; x.bs = bs; x.to = to; x.gap = gap;
    exp_q.push_back(x);
  endfunction

  // Monitor: one comparison per observed engine-control event.
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (eng_rst || eng_go || frame_done) begin
        k = frame_done ? K_DONE : (eng_go ? K_GO : K_RST);
        n_cmp++;
        n_ev++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got kind=%0d ic=%0d bs=%0d to=%0d at cycle %0d, required no event",
                   k, iter_cnt, bank_sel, timeout, cyc);
        end else begin
          e = exp_q.pop_front();
          if (k != e.kind || int'(iter_cnt) != e.ic || int'(bank_sel) != e.bs ||
              int'(timeout) != e.to || busy != 1'b1 ||
              (e.gap >= 0 && cyc - last_cyc != e.gap)) begin
            n_fail++;
            $display("FAIL event%0d: got kind=%0d ic=%0d bs=%0d to=%0d busy=%0d gap=%0d, required kind=%0d ic=%0d bs=%0d to=%0d busy=1 gap=%0d",
                     n_ev, k, iter_cnt, bank_sel, timeout, busy, cyc - last_cyc,
                     e.kind, e.ic, e.bs, e.to, e.gap);
          end else begin
            $display("event%0d ok: kind=%0d ic=%0d bs=%0d to=%0d", n_ev, k,
                     iter_cnt, bank_sel, timeout);
          end
        end
        last_cyc = cyc;
      end
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end else begin
      $display("check %s ok: %0d", nm, act);
    end
  endtask

  task automatic start_frame(input logic [ITER_W-1:0] n);
    start = 1'b1;
    iters = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_go(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (eng_go) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_go: got no eng_go within 50 cycles, required eng_go");
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({nm, "_idle"}, int'(ok), 1);
    check({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Engine model: done pulse dly cycles after go; optionally a spurious done
  // during the GO cycle and two ignored start pulses during WAIT.
  task automatic engine_iter(input int dly, input bit spur, input bit poke);
    bit ok;
    wait_go(ok);
    if (ok) begin
      if (spur) eng_done = 1'b1;
      for (int i = 1; i <= dly; i++) begin
        @(negedge clk);
        eng_done = 1'b0;
        start = poke && (i == 3 || i == 6);
        if (start) iters = 6'd5;
      end
      start = 1'b0;
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "global timeout");
  end

  initial begin
    bit ok;
    rst = 1'b1; start = 1'b0; abort = 1'b0; eng_done = 1'b0; iters = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {eng_go, eng_rst, bank_sel, busy, frame_done, timeout}, 0);
    check("rst_iter_cnt", iter_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: three iterations, engine answers 10 cycles after each go.
    push(K_RST, 0, 0, 0, -1); push(K_GO, 0, 0, 0, 1);
    push(K_RST, 1, 1, 0, 12); push(K_GO, 1, 1, 0, 1);
    push(K_RST, 2, 0, 0, 12); push(K_GO, 2, 0, 0, 1);
    push(K_DONE, 3, 1, 0, 12);
    start_frame(6'd3);
    repeat (3) engine_iter(10, 1'b0, 1'b0);
    wait_idle("t1");
    check("t1_iter_cnt", iter_cnt, 3);
    check("t1_bank_sel", bank_sel, 1);

    // 2: iters=0 runs exactly one iteration.
    push(K_RST, 0, 0, 0, -1); push(K_GO, 0, 0, 0, 1);
    push(K_DONE, 1, 1, 0, 12);
    start_frame(6'd0);
    engine_iter(10, 1'b0, 1'b0);
    wait_idle("t2");
    check("t2_iter_cnt", iter_cnt, 1);
    check("t2_bank_sel", bank_sel, 1);

    // 3: engine hangs; ERR after TMO WAIT cycles, next start clears timeout.
    push(K_RST, 0, 0, 0, -1); push(K_GO, 0, 0, 0, 1);
    push(K_RST, 0, 0, 1, TMO + 1);
    start_frame(6'd1);
    wait_go(ok);
    wait_idle("t3");
    check("t3_timeout", timeout, 1);
    push(K_RST, 0, 0, 0, -1); push(K_GO, 0, 0, 0, 1);
    push(K_DONE, 1, 1, 0, 12);
    start_frame(6'd1);
    check("t3_timeout_cleared", timeout, 0);
    engine_iter(10, 1'b0, 1'b0);
    wait_idle("t3b");

    // 4: abort together with done in iteration 2 of 4.
    push(K_RST, 0, 0, 0, -1); push(K_GO, 0, 0, 0, 1);
    push(K_RST, 1, 1, 0, 12); push(K_GO, 1, 1, 0, 1);
    push(K_RST, 1, 1, 0, 11);
    start_frame(6'd4);
    engine_iter(10, 1'b0, 1'b0);
    wait_go(ok);
    repeat (10) @(negedge clk);
    eng_done = 1'b1; abort = 1'b1;
    @(negedge clk);
    eng_done = 1'b0; abort = 1'b0;
    wait_idle("t4");
    check("t4_iter_cnt", iter_cnt, 1);
    check("t4_bank_sel", bank_sel, 1);

    // 5: spurious done in IDLE and GO, extra starts during WAIT.
    eng_done = 1'b1;
    repeat (2) @(negedge clk);
    eng_done = 1'b0;
    check("t5_idle_busy", busy, 0);
    check("t5_idle_iter_cnt", iter_cnt, 1);
    push(K_RST, 0, 0, 0, -1); push(K_GO, 0, 0, 0, 1);
    push(K_RST, 1, 1, 0, 12); push(K_GO, 1, 1, 0, 1);
    push(K_DONE, 2, 0, 0, 12);
    start_frame(6'd2);
    engine_iter(10, 1'b1, 1'b1);
    engine_iter(10, 1'b0, 1'b0);
    wait_idle("t5");
    check("t5_iter_cnt", iter_cnt, 2);

    // 6: async reset in WAIT with iter_cnt=2, then a clean one-iteration frame.
    push(K_RST, 0, 0, 0, -1); push(K_GO, 0, 0, 0, 1);
    push(K_RST, 1, 1, 0, 12); push(K_GO, 1, 1, 0, 1);
    push(K_RST, 2, 0, 0, 12); push(K_GO, 2, 0, 0, 1);
    start_frame(6'd4);
    repeat (2) engine_iter(10, 1'b0, 1'b0);
    wait_go(ok);
    repeat (3) @(negedge clk);
    check("t6_pre_iter_cnt", iter_cnt, 2);
    #2 rst = 1'b1;
    #1;
    check("t6_async_outputs", {eng_go, eng_rst, bank_sel, busy, frame_done, timeout}, 0);
    check("t6_async_iter_cnt", iter_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    check("t6_queue_empty", exp_q.size(), 0);
    @(negedge clk);
    push(K_RST, 0, 0, 0, -1); push(K_GO, 0, 0, 0, 1);
    push(K_DONE, 1, 1, 0, 12);
    start_frame(6'd1);
    engine_iter(10, 1'b0, 1'b0);
    wait_idle("t6");
    check("t6_iter_cnt", iter_cnt, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
